// File: rtl/event_monitor.sv
// event_monitor: checks home-controller events, counts them, and queues them for a timed 7-segment display
module event_monitor #(
   parameter int HOLD  = 8,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [2:0]       code,
   input  logic [5:0]       act,
   input  logic [2:0]       sel,
   output logic [2:0]       shown,
   output logic [6:0]       seg,
   output logic [2:0]       level,
   output logic [CNT_W-1:0] cnt,
   output logic             err,
   output logic             ovf
);
   typedef enum logic {IDLE, SHOW} state_t;
   state_t           state;
   logic [2:0]       prev_code;
   logic [2:0]       fifo [4];
   logic [1:0]       rd_ptr, wr_ptr;
   logic [7:0]       timer;
   logic [CNT_W-1:0] counters [8];
   logic             valid, accept, pop, push;
   // Classify the code/act pair and decide this edge's FIFO push and pop
   always_comb begin
      valid  = (code == 3'd0) ? (act == 6'd0) : (code != 3'd7) && (act == (6'd1 << (3'd6 - code)));
      accept = valid && code != 3'd0 && code != prev_code;
      pop    = level != 3'd0 && (state == IDLE || timer == 8'd0);
      push   = accept && (level != 3'd4 || pop);
   end
   // Event intake: sticky flags, edge detection, saturating counters and FIFO storage
   always_ff @(posedge Clk) begin
      if (Rst) begin
         err       <= 1'b0;
         ovf       <= 1'b0;
         prev_code <= 3'd0;
         rd_ptr    <= 2'd0;
         wr_ptr    <= 2'd0;
         level     <= 3'd0;
         for (int i = 0; i < 8; i++) counters[i] <= '0;
      end else begin
         prev_code <= code;
         if (!valid) err <= 1'b1;
         if (accept && !push) ovf <= 1'b1;
         if (accept && counters[code] != '1) counters[code] <= counters[code] + CNT_W'(1);
         if (push) begin
            fifo[wr_ptr] <= code;
            wr_ptr       <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         level <= level + 3'(push) - 3'(pop);
      end
   end
   // Display FSM: take the FIFO head and hold it for HOLD cycles, chaining without gaps
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         shown <= 3'd0;
         timer <= 8'd0;
      end else if (pop) begin
         state <= SHOW;
         shown <= fifo[rd_ptr];
         timer <= 8'(HOLD - 1);
      end else if (state == SHOW) begin
         if (timer == 8'd0) begin
            state <= IDLE;
            shown <= 3'd0;
         end else timer <= timer - 8'd1;
      end
   end
   // Segment decode of the shown code and the counter read port
   always_comb begin
      case (shown)
         3'd1:    seg = 7'b0000110;
         3'd2:    seg = 7'b1011011;
         3'd3:    seg = 7'b1001111;
         3'd4:    seg = 7'b1100110;
         3'd5:    seg = 7'b1101101;
         3'd6:    seg = 7'b1111101;
         default: seg = 7'b0000000;
      endcase
      cnt = (sel == 3'd0 || sel == 3'd7) ? '0 : counters[sel];
   end
endmodule

// File: tb/tb_event_monitor.sv
// tb_event_monitor: directed scenarios with a display-order scoreboard for event_monitor
module tb_event_monitor;
   localparam int HOLD = 8;
   logic       Clk = 1'b0;
   logic       Rst;
   logic [2:0] code, sel;
   logic [5:0] act;
   logic [2:0] shown, level;
   logic [6:0] seg;
   logic [7:0] cnt;
   logic       err, ovf;
   int         n_chk = 0;
   int         n_fail = 0;
   int         exp_q[$];
   bit         sb_on = 1'b1;
   int         run = 0;
   logic [2:0] prv = 3'd0;

   event_monitor #(.HOLD(HOLD), .CNT_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .code(code), .act(act), .sel(sel),
      .shown(shown), .seg(seg), .level(level), .cnt(cnt), .err(err), .ovf(ovf)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [5:0] act_of(input int c);
      case (c)
         1:       return 6'b100000;
         2:       return 6'b010000;
         3:       return 6'b001000;
         4:       return 6'b000100;
         5:       return 6'b000010;
         6:       return 6'b000001;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [6:0] seg_of(input logic [2:0] c);
      case (c)
         3'd1:    return 7'b0000110;
         3'd2:    return 7'b1011011;
         3'd3:    return 7'b1001111;
         3'd4:    return 7'b1100110;
         3'd5:    return 7'b1101101;
         3'd6:    return 7'b1111101;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic tick(input logic [2:0] c, input logic [5:0] a);
      code = c;
      act  = a;
      @(posedge Clk);
      #1;
   endtask

   task automatic ev(input int c);
      tick(3'(c), act_of(c));
   endtask

   task automatic rd(input string tag, input logic [2:0] s, input int e);
      sel = s;
      #1;
      chk(tag, cnt, e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (shown == 3'd0 && level == 3'd0) break;
         tick(3'd0, 6'd0);
      end
      chk("idle_timeout", 32'(shown == 3'd0 && level == 3'd0), 1);
   endtask

   // Scoreboard: every display run must match the next expected code and last exactly HOLD cycles
   always @(negedge Clk) begin
      if (Rst || !sb_on) begin
         run = 0;
         prv = 3'd0;
      end else begin
         if (shown != prv || (shown != 3'd0 && run == HOLD)) begin
            if (prv != 3'd0) chk("hold_len", run, HOLD);
            if (shown != 3'd0) begin
               if (exp_q.size() == 0) chk("unexpected_show", shown, 0);
               else chk("show_order", shown, exp_q.pop_front());
               chk("seg_decode", seg, seg_of(shown));
            end
            run = 1;
         end else if (shown != 3'd0) run++;
         prv = shown;
      end
   end

   initial begin
      int seq[4] = '{3, 5, 6, 2};
      Rst = 1'b1; code = 3'd0; act = 6'd0; sel = 3'd0;
      tick(3'd0, 6'd0);
      tick(3'd0, 6'd0);
      chk("rst_shown", shown, 0);
      chk("rst_seg", seg, 0);
      chk("rst_level", level, 0);
      chk("rst_err", err, 0);
      chk("rst_ovf", ovf, 0);
      rd("rst_cnt1", 3'd1, 0);
      Rst = 1'b0;
      // single event held for several cycles
      exp_q.push_back(1);
      ev(1);
      chk("lat_level", level, 1);
      chk("lat_shown", shown, 0);
      ev(1);
      chk("held_shown", shown, 1);
      chk("held_seg", seg, 7'b0000110);
      chk("held_level", level, 0);
      repeat (3) ev(1);
      rd("held_cnt1", 3'd1, 1);
      wait_idle();
      // back-to-back events
      foreach (seq[i]) begin
         exp_q.push_back(seq[i]);
         ev(seq[i]);
      end
      chk("b2b_level", level, 3);
      chk("b2b_ovf", ovf, 0);
      wait_idle();
      // overflow while an event is on display
      exp_q.push_back(3);
      ev(3);
      tick(3'd0, 6'd0);
      chk("ovf_first_shown", shown, 3);
      for (int c = 1; c <= 6; c++) begin
         if (c <= 4) exp_q.push_back(c);
         ev(c);
         if (c == 4) begin
            chk("ovf_full_level", level, 4);
            chk("ovf_not_yet", ovf, 0);
         end
      end
      chk("ovf_level", level, 4);
      chk("ovf_flag", ovf, 1);
      rd("ovf_cnt1", 3'd1, 2);
      rd("ovf_cnt2", 3'd2, 2);
      rd("ovf_cnt3", 3'd3, 3);
      rd("ovf_cnt4", 3'd4, 1);
      rd("ovf_cnt5", 3'd5, 2);
      rd("ovf_cnt6", 3'd6, 2);
      wait_idle();
      // inconsistent code/act pairs
      chk("pre_err", err, 0);
      tick(3'd4, 6'b000001);
      chk("mm_err", err, 1);
      chk("mm_level", level, 0);
      rd("mm_cnt4", 3'd4, 1);
      tick(3'd7, 6'd0);
      chk("illegal_err", err, 1);
      chk("illegal_level", level, 0);
      tick(3'd0, 6'd0);
      // reset in the middle of a display with two queued
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      ev(1);
      ev(2);
      ev(3);
      chk("pre_rst_level", level, 2);
      chk("pre_rst_shown", shown, 1);
      Rst = 1'b1;
      exp_q.delete();
      ev(4);
      chk("mid_rst_shown", shown, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_ovf", ovf, 0);
      rd("mid_rst_cnt4", 3'd4, 0);
      rd("mid_rst_cnt1", 3'd1, 0);
      Rst = 1'b0;
      tick(3'd0, 6'd0);
      chk("post_rst_level", level, 0);
      // counter saturation
      sb_on = 1'b0;
      repeat (300) begin
         ev(5);
         tick(3'd0, 6'd0);
      end
      rd("sat_cnt5", 3'd5, 255);
      rd("sat_sel0", 3'd0, 0);
      rd("sat_sel7", 3'd7, 0);
      chk("sat_err", err, 0);
      chk("sat_ovf", ovf, 1);
      Rst = 1'b1;
      tick(3'd0, 6'd0);
      Rst = 1'b0;
      exp_q.delete();
      sb_on = 1'b1;
      tick(3'd0, 6'd0);
      // clean event after recovery
      exp_q.push_back(6);
      ev(6);
      wait_idle();
      rd("final_cnt6", 3'd6, 1);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
